// File: rtl/dncnt_timer.sv
// dncnt_timer: WIDTH-bit programmable counter/timer for TOM-side timing.
// A prescaler divides the count enable, four modes select down-wrap,
// down-stop-at-zero, down-auto-reload or up-wrap counting, a registered
// terminal-count pulse feeds interrupt logic, and a combinational
// borrow/carry output lets several stages be chained into a wider counter.
module dncnt_timer #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             rld_we,
    input  logic [WIDTH-1:0] rld_d,
    input  logic [PRE_W-1:0] pre_div,
    input  logic             ci,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             tc,
    output logic             zero
);

    typedef enum logic [1:0] {
        MODE_DOWN_WRAP   = 2'b00,
        MODE_DOWN_STOP   = 2'b01,
        MODE_DOWN_RELOAD = 2'b10,
        MODE_UP_WRAP     = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    mode_t            mode_sel;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] q_next;
    logic [PRE_W-1:0] pc;
    logic             tick;
    logic             term;

    assign mode_sel = mode_t'(mode);
    assign tick     = ci & (pc == '0);
    assign zero     = (q == '0);
    assign co       = tick & term;

    // Terminal-event condition for the current count in the selected mode
    always_comb begin
        term = 1'b0;
        case (mode_sel)
            MODE_DOWN_WRAP:   term = zero;
            MODE_DOWN_STOP:   term = (q == ONE);
            MODE_DOWN_RELOAD: term = zero;
            MODE_UP_WRAP:     term = (q == ALL_ONES);
            default:          term = 1'b0;
        endcase
    end

    // Next count value: a load always wins over a tick in the same cycle
    always_comb begin
        q_next = q;
        if (ld) begin
            q_next = d;
        end else if (tick) begin
            case (mode_sel)
                MODE_DOWN_WRAP:   q_next = q - ONE;
                MODE_DOWN_STOP:   q_next = zero ? q : (q - ONE);
                MODE_DOWN_RELOAD: q_next = zero ? reload : (q - ONE);
                MODE_UP_WRAP:     q_next = q + ONE;
                default:          q_next = q;
            endcase
        end
    end

    // Counter and terminal-count pulse; a load suppresses that cycle's event
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            q  <= '0;
            tc <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= co & ~ld;
        end
    end

    // Prescaler: counts enabled cycles down to zero, then restarts at pre_div
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pc <= '0;
        end else if (ld) begin
            pc <= pre_div;
        end else if (ci) begin
            pc <= (pc == '0) ? pre_div : (pc - PRE_W'(1));
        end
    end

    // Reload register; a reload in the same cycle still sees the old value
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            reload <= '0;
        end else if (rld_we) begin
            reload <= rld_d;
        end
    end

endmodule

// File: tb/tb_dncnt_timer.sv
// tb_dncnt_timer: scenario-driven bench for dncnt_timer. Each step drives
// inputs, pushes the expected post-edge count and tc into a scoreboard, checks
// the zero-latency outputs, then pops and compares after the clock edge.
module tb_dncnt_timer;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        ld;
    logic [15:0] d;
    logic        rld_we;
    logic [15:0] rld_d;
    logic [7:0]  pre_div;
    logic        ci;
    logic [1:0]  mode;
    logic [15:0] q;
    logic        co;
    logic        tc;
    logic        zero;

    logic        c_ld;
    logic        c_ci;
    logic [3:0]  lo_q;
    logic [3:0]  hi_q;
    logic        lo_co;
    logic        hi_co;
    logic        lo_tc;
    logic        hi_tc;
    logic        lo_zero;
    logic        hi_zero;

    int   total = 0;
    int   bad   = 0;
    int   exp_q[$];
    logic exp_tc[$];
    int   cur_q = 0;

    typedef struct {
        int rst; int ld; int d; int rld_we; int rld_d;
        int pre_div; int ci; int mode; int eq; int etc; int eco;
    } step_t;

    dncnt_timer #(.WIDTH(16), .PRE_W(8)) dut (
        .sys_clk(sys_clk), .reset(reset), .ld(ld), .d(d),
        .rld_we(rld_we), .rld_d(rld_d), .pre_div(pre_div), .ci(ci),
        .mode(mode), .q(q), .co(co), .tc(tc), .zero(zero)
    );

    dncnt_timer #(.WIDTH(4), .PRE_W(8)) lo_stage (
        .sys_clk(sys_clk), .reset(reset), .ld(c_ld), .d(4'd0),
        .rld_we(1'b0), .rld_d(4'd0), .pre_div(8'd0), .ci(c_ci),
        .mode(2'b00), .q(lo_q), .co(lo_co), .tc(lo_tc), .zero(lo_zero)
    );

    dncnt_timer #(.WIDTH(4), .PRE_W(8)) hi_stage (
        .sys_clk(sys_clk), .reset(reset), .ld(c_ld), .d(4'd0),
        .rld_we(1'b0), .rld_d(4'd0), .pre_div(8'd0), .ci(lo_co),
        .mode(2'b00), .q(hi_q), .co(hi_co), .tc(hi_tc), .zero(hi_zero)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic apply_step(input step_t s);
        reset   = 1'(s.rst);
        ld      = 1'(s.ld);
        d       = 16'(s.d);
        rld_we  = 1'(s.rld_we);
        rld_d   = 16'(s.rld_d);
        pre_div = 8'(s.pre_div);
        ci      = 1'(s.ci);
        mode    = 2'(s.mode);
        exp_q.push_back(s.eq);
        exp_tc.push_back(1'(s.etc));
    endtask

    task automatic test_reset();
        int   pq;
        logic ptc;
        reset = 1'b1; ld = 1'b0; d = '0; rld_we = 1'b0; rld_d = '0;
        pre_div = '0; ci = 1'b0; mode = 2'b00; c_ld = 1'b0; c_ci = 1'b0;
        exp_q.push_back(0);
        exp_tc.push_back(1'b0);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        pq = exp_q.pop_front();
        ptc = exp_tc.pop_front();
        total++;
        if (q !== 16'(pq)) begin bad++; $display("FAIL reset q: got %h want %h", q, 16'(pq)); end
        total++;
        if (tc !== ptc) begin bad++; $display("FAIL reset tc: got %b want %b", tc, ptc); end
        total++;
        if (zero !== 1'b1) begin bad++; $display("FAIL reset zero: got %b want 1", zero); end
        total++;
        if (co !== 1'b0) begin bad++; $display("FAIL reset co: got %b want 0", co); end
        total++;
        if ({hi_q, lo_q} !== 8'h00) begin bad++; $display("FAIL reset cascade q: got %h want 00", {hi_q, lo_q}); end
        reset = 1'b0;
        cur_q = 0;
    endtask

    task automatic test_mode_down_wrap();
        step_t st [6] = '{
            '{0,1,3,0,0,0,1,0, 3,0,1},
            '{0,0,0,0,0,0,1,0, 2,0,0},
            '{0,0,0,0,0,0,1,0, 1,0,0},
            '{0,0,0,0,0,0,1,0, 0,0,0},
            '{0,0,0,0,0,0,1,0, 'hFFFF,1,1},
            '{0,0,0,0,0,0,1,0, 'hFFFE,0,0}
        };
        int   pq;
        logic ptc;
        for (int i = 0; i < 6; i++) begin
            apply_step(st[i]);
            #1;
            total++;
            if (co !== 1'(st[i].eco)) begin bad++; $display("FAIL down_wrap[%0d] co: got %b want %b", i, co, 1'(st[i].eco)); end
            total++;
            if (zero !== (cur_q == 0)) begin bad++; $display("FAIL down_wrap[%0d] zero: got %b want %b", i, zero, cur_q == 0); end
            @(posedge sys_clk);
            #1;
            pq = exp_q.pop_front();
            ptc = exp_tc.pop_front();
            total++;
            if (q !== 16'(pq)) begin bad++; $display("FAIL down_wrap[%0d] q: got %h want %h", i, q, 16'(pq)); end
            total++;
            if (tc !== ptc) begin bad++; $display("FAIL down_wrap[%0d] tc: got %b want %b", i, tc, ptc); end
            cur_q = pq;
        end
    endtask

    task automatic test_mode_down_stop();
        step_t st [7] = '{
            '{0,1,2,0,0,0,1,1, 2,0,0},
            '{0,0,0,0,0,0,1,1, 1,0,0},
            '{0,0,0,0,0,0,1,1, 0,1,1},
            '{0,0,0,0,0,0,1,1, 0,0,0},
            '{0,0,0,0,0,0,1,1, 0,0,0},
            '{0,0,0,0,0,0,1,1, 0,0,0},
            '{0,0,0,0,0,0,1,1, 0,0,0}
        };
        int   pq;
        logic ptc;
        for (int i = 0; i < 7; i++) begin
            apply_step(st[i]);
            #1;
            total++;
            if (co !== 1'(st[i].eco)) begin bad++; $display("FAIL down_stop[%0d] co: got %b want %b", i, co, 1'(st[i].eco)); end
            total++;
            if (zero !== (cur_q == 0)) begin bad++; $display("FAIL down_stop[%0d] zero: got %b want %b", i, zero, cur_q == 0); end
            @(posedge sys_clk);
            #1;
            pq = exp_q.pop_front();
            ptc = exp_tc.pop_front();
            total++;
            if (q !== 16'(pq)) begin bad++; $display("FAIL down_stop[%0d] q: got %h want %h", i, q, 16'(pq)); end
            total++;
            if (tc !== ptc) begin bad++; $display("FAIL down_stop[%0d] tc: got %b want %b", i, tc, ptc); end
            cur_q = pq;
        end
    endtask

    task automatic test_mode_auto_reload();
        step_t st [9] = '{
            '{0,1,1,1,5,0,1,2, 1,0,1},
            '{0,0,0,0,0,0,1,2, 0,0,0},
            '{0,0,0,0,0,0,1,2, 5,1,1},
            '{0,0,0,0,0,0,1,2, 4,0,0},
            '{0,1,0,0,0,0,1,2, 0,0,0},
            '{0,0,0,1,9,0,1,2, 5,1,1},
            '{0,0,0,0,0,0,1,2, 4,0,0},
            '{0,1,0,0,0,0,1,2, 0,0,0},
            '{0,0,0,0,0,0,1,2, 9,1,1}
        };
        int   pq;
        logic ptc;
        for (int i = 0; i < 9; i++) begin
            apply_step(st[i]);
            #1;
            total++;
            if (co !== 1'(st[i].eco)) begin bad++; $display("FAIL auto_reload[%0d] co: got %b want %b", i, co, 1'(st[i].eco)); end
            total++;
            if (zero !== (cur_q == 0)) begin bad++; $display("FAIL auto_reload[%0d] zero: got %b want %b", i, zero, cur_q == 0); end
            @(posedge sys_clk);
            #1;
            pq = exp_q.pop_front();
            ptc = exp_tc.pop_front();
            total++;
            if (q !== 16'(pq)) begin bad++; $display("FAIL auto_reload[%0d] q: got %h want %h", i, q, 16'(pq)); end
            total++;
            if (tc !== ptc) begin bad++; $display("FAIL auto_reload[%0d] tc: got %b want %b", i, tc, ptc); end
            cur_q = pq;
        end
    endtask

    task automatic test_prescaler();
        step_t st [16] = '{
            '{0,1,'hFFFE,0,0,2,1,3, 'hFFFE,0,0},
            '{0,0,0,0,0,2,1,3, 'hFFFE,0,0},
            '{0,0,0,0,0,2,1,3, 'hFFFE,0,0},
            '{0,0,0,0,0,2,1,3, 'hFFFF,0,0},
            '{0,0,0,0,0,2,1,3, 'hFFFF,0,0},
            '{0,0,0,0,0,2,1,3, 'hFFFF,0,0},
            '{0,0,0,0,0,2,1,3, 0,1,1},
            '{0,0,0,0,0,2,1,3, 0,0,0},
            '{0,0,0,0,0,2,1,3, 0,0,0},
            '{0,0,0,0,0,2,1,3, 1,0,0},
            '{0,0,0,0,0,2,1,3, 1,0,0},
            '{0,0,0,0,0,2,0,3, 1,0,0},
            '{0,0,0,0,0,2,0,3, 1,0,0},
            '{0,0,0,0,0,2,0,3, 1,0,0},
            '{0,0,0,0,0,2,1,3, 1,0,0},
            '{0,0,0,0,0,2,1,3, 2,0,0}
        };
        int   pq;
        logic ptc;
        for (int i = 0; i < 16; i++) begin
            apply_step(st[i]);
            #1;
            total++;
            if (co !== 1'(st[i].eco)) begin bad++; $display("FAIL prescaler[%0d] co: got %b want %b", i, co, 1'(st[i].eco)); end
            total++;
            if (zero !== (cur_q == 0)) begin bad++; $display("FAIL prescaler[%0d] zero: got %b want %b", i, zero, cur_q == 0); end
            @(posedge sys_clk);
            #1;
            pq = exp_q.pop_front();
            ptc = exp_tc.pop_front();
            total++;
            if (q !== 16'(pq)) begin bad++; $display("FAIL prescaler[%0d] q: got %h want %h", i, q, 16'(pq)); end
            total++;
            if (tc !== ptc) begin bad++; $display("FAIL prescaler[%0d] tc: got %b want %b", i, tc, ptc); end
            cur_q = pq;
        end
    endtask

    task automatic test_priority_and_reset();
        step_t st [7] = '{
            '{0,1,0,0,0,0,1,0, 0,0,0},
            '{0,1,7,0,0,0,1,0, 7,0,1},
            '{0,1,0,1,'hAB,0,1,0, 0,0,0},
            '{1,0,0,0,0,0,1,0, 0,0,1},
            '{0,1,0,0,0,3,0,0, 0,0,0},
            '{1,0,0,0,0,3,0,0, 0,0,0},
            '{0,0,0,0,0,3,1,2, 0,1,1}
        };
        int   pq;
        logic ptc;
        for (int i = 0; i < 7; i++) begin
            apply_step(st[i]);
            #1;
            total++;
            if (co !== 1'(st[i].eco)) begin bad++; $display("FAIL priority[%0d] co: got %b want %b", i, co, 1'(st[i].eco)); end
            total++;
            if (zero !== (cur_q == 0)) begin bad++; $display("FAIL priority[%0d] zero: got %b want %b", i, zero, cur_q == 0); end
            @(posedge sys_clk);
            #1;
            pq = exp_q.pop_front();
            ptc = exp_tc.pop_front();
            total++;
            if (q !== 16'(pq)) begin bad++; $display("FAIL priority[%0d] q: got %h want %h", i, q, 16'(pq)); end
            total++;
            if (tc !== ptc) begin bad++; $display("FAIL priority[%0d] tc: got %b want %b", i, tc, ptc); end
            cur_q = pq;
        end
        reset = 1'b0;
        ci = 1'b0;
    endtask

    task automatic test_cascade();
        int   pq;
        logic ptc;
        int   prev = 0;
        c_ld = 1'b1;
        c_ci = 1'b0;
        exp_q.push_back(0);
        exp_tc.push_back(1'b0);
        @(posedge sys_clk);
        #1;
        pq = exp_q.pop_front();
        ptc = exp_tc.pop_front();
        total++;
        if ({hi_q, lo_q} !== 8'(pq)) begin bad++; $display("FAIL cascade_load q: got %h want %h", {hi_q, lo_q}, 8'(pq)); end
        total++;
        if (hi_tc !== ptc) begin bad++; $display("FAIL cascade_load hi_tc: got %b want %b", hi_tc, ptc); end
        c_ld = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            c_ci = 1'b1;
            exp_q.push_back((256 - n) % 256);
            exp_tc.push_back(n == 1);
            #1;
            total++;
            if (lo_co !== ((prev % 16) == 0)) begin bad++; $display("FAIL cascade[%0d] lo_co: got %b want %b", n, lo_co, (prev % 16) == 0); end
            @(posedge sys_clk);
            #1;
            pq = exp_q.pop_front();
            ptc = exp_tc.pop_front();
            total++;
            if ({hi_q, lo_q} !== 8'(pq)) begin bad++; $display("FAIL cascade[%0d] q: got %h want %h", n, {hi_q, lo_q}, 8'(pq)); end
            total++;
            if (hi_tc !== ptc) begin bad++; $display("FAIL cascade[%0d] hi_tc: got %b want %b", n, hi_tc, ptc); end
            prev = pq;
        end
        c_ci = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode_down_wrap();
        test_mode_down_stop();
        test_mode_auto_reload();
        test_prescaler();
        test_priority_and_reset();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
